// File: rtl/pipe_sequencer_if.sv
// Handshake bundle between the pipe sequencer and the surrounding core datapath / debug port.
// The master side is the core and debug port; the slave side is the sequencer.
interface pipe_sequencer_if #(
  parameter int PC_W = 12
);
  logic            halt_req;
  logic            run_req;
  logic            step_req;
  logic            redirect_EX;
  logic [PC_W-1:0] target_EX;
  logic [4:0]      rs1_EX;
  logic [4:0]      rs2_EX;
  logic            regwrite_WB;
  logic [4:0]      rd_WB;

  logic [PC_W-1:0] pc_FETCH;
  logic            fetch_en;
  logic            valid_EX;
  logic            valid_WB;
  logic            fwd_a;
  logic            fwd_b;
  logic            halted;
  logic            step_ack;
  logic [31:0]     instret;

  modport master (
    output halt_req, run_req, step_req, redirect_EX, target_EX,
           rs1_EX, rs2_EX, regwrite_WB, rd_WB,
    input  pc_FETCH, fetch_en, valid_EX, valid_WB, fwd_a, fwd_b,
           halted, step_ack, instret
  );

  modport slave (
    input  halt_req, run_req, step_req, redirect_EX, target_EX,
           rs1_EX, rs2_EX, regwrite_WB, rd_WB,
    output pc_FETCH, fetch_en, valid_EX, valid_WB, fwd_a, fwd_b,
           halted, step_ack, instret
  );
endinterface

// File: rtl/pipe_sequencer.sv
// Fetch/EX/WB sequencing for the two-stage RV32 core: fetch PC, stage valids, branch squash,
// WB->EX forwarding selects, halt/run/single-step debug control and retired-instruction count.
module pipe_sequencer #(
  parameter int              PC_W        = 12,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              BOOT_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  pipe_sequencer_if.slave bus
);

  localparam int CNT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_RUN,
    S_HALT,
    S_STEP_IF,
    S_STEP_EX,
    S_STEP_WB
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] boot_cnt;
  logic [PC_W-1:0]  pc;
  logic             valid_ex;
  logic             valid_wb;
  logic [31:0]      instret;
  logic             fetch_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= next_state;
    end
  end

  // The boot counter holds BOOT for BOOT_CYCLES cycles; a count of 0 or 1 both leave after one edge.
  always_comb begin
    next_state = state;
    fetch_en   = 1'b0;
    case (state)
      S_BOOT: begin
        if (boot_cnt <= CNT_W'(1)) next_state = S_RUN;
      end
      S_RUN: begin
        fetch_en = 1'b1;
        if (bus.halt_req) next_state = S_HALT;
      end
      S_HALT: begin
        if (!bus.halt_req && bus.run_req) next_state = S_RUN;
        else if (bus.step_req)            next_state = S_STEP_IF;
      end
      S_STEP_IF: begin
        fetch_en   = 1'b1;
        next_state = S_STEP_EX;
      end
      S_STEP_EX: next_state = S_STEP_WB;
      S_STEP_WB: next_state = S_HALT;
      default:   next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_cnt <= CNT_W'(BOOT_CYCLES);
    end else if (state == S_BOOT && boot_cnt != '0) begin
      boot_cnt <= boot_cnt - CNT_W'(1);
    end
  end

  // A taken branch in EX beats any fetch: the slot fetched behind it is turned into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      valid_ex <= 1'b0;
      valid_wb <= 1'b0;
      instret  <= '0;
    end else begin
      if (bus.redirect_EX && valid_ex) begin
        pc       <= bus.target_EX;
        valid_ex <= 1'b0;
      end else if (fetch_en) begin
        pc       <= pc + PC_W'(1);
        valid_ex <= 1'b1;
      end else begin
        valid_ex <= 1'b0;
      end
      valid_wb <= valid_ex;
      if (valid_wb) instret <= instret + 32'd1;
    end
  end

  assign bus.pc_FETCH = pc;
  assign bus.fetch_en = fetch_en;
  assign bus.valid_EX = valid_ex;
  assign bus.valid_WB = valid_wb;
  assign bus.instret  = instret;
  assign bus.halted   = (state == S_HALT);
  assign bus.step_ack = (state == S_STEP_WB);
  assign bus.fwd_a    = valid_wb && bus.regwrite_WB && (bus.rd_WB != 5'd0) && (bus.rd_WB == bus.rs1_EX);
  assign bus.fwd_b    = valid_wb && bus.regwrite_WB && (bus.rd_WB != 5'd0) && (bus.rd_WB == bus.rs2_EX);

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: boot, run, redirect/squash, forwarding, halt/step/run,
// PC wrap and asynchronous reset in the middle of a single step.
module tb_pipe_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_sequencer_if #(.PC_W(12)) bus ();

  pipe_sequencer #(
    .PC_W(12),
    .RESET_PC(12'h000),
    .BOOT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    bus.halt_req    = 1'b0;
    bus.run_req     = 1'b0;
    bus.step_req    = 1'b0;
    bus.redirect_EX = 1'b0;
    bus.target_EX   = 12'h000;
    bus.rs1_EX      = 5'd0;
    bus.rs2_EX      = 5'd0;
    bus.regwrite_WB = 1'b0;
    bus.rd_WB       = 5'd0;

    #2;
    checkOutput("reset_pc",       32'(bus.pc_FETCH), 32'h0);
    checkOutput("reset_valid_ex", 32'(bus.valid_EX), 32'h0);
    checkOutput("reset_valid_wb", 32'(bus.valid_WB), 32'h0);
    checkOutput("reset_halted",   32'(bus.halted),   32'h0);
    checkOutput("reset_fetch_en", 32'(bus.fetch_en), 32'h0);
    checkOutput("reset_instret",  bus.instret,       32'h0);

    #10;
    rst = 1'b0;
    checkOutput("boot_fetch_en_0", 32'(bus.fetch_en), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("boot_fetch_en_%0d", i), 32'(bus.fetch_en), 32'h0);
    end
    applyStimulus();
    checkOutput("run_fetch_en", 32'(bus.fetch_en), 32'h1);
    checkOutput("run_pc0",      32'(bus.pc_FETCH), 32'h0);
    checkOutput("run_vex0",     32'(bus.valid_EX), 32'h0);

    applyStimulus();
    checkOutput("run_pc1",  32'(bus.pc_FETCH), 32'h1);
    checkOutput("run_vex1", 32'(bus.valid_EX), 32'h1);
    checkOutput("run_vwb1", 32'(bus.valid_WB), 32'h0);
    applyStimulus();
    checkOutput("run_pc2",  32'(bus.pc_FETCH), 32'h2);
    checkOutput("run_vwb2", 32'(bus.valid_WB), 32'h1);
    checkOutput("run_ir2",  bus.instret,       32'd0);
    for (int i = 3; i <= 6; i++) applyStimulus();
    checkOutput("run_pc6", 32'(bus.pc_FETCH), 32'h6);
    checkOutput("run_ir6", bus.instret,       32'd4);

    // Forwarding with a live producer in WB
    bus.regwrite_WB = 1'b1;
    bus.rd_WB       = 5'd5;
    bus.rs1_EX      = 5'd5;
    bus.rs2_EX      = 5'd5;
    #1;
    checkOutput("fwd_a_hit", 32'(bus.fwd_a), 32'h1);
    checkOutput("fwd_b_hit", 32'(bus.fwd_b), 32'h1);
    bus.rs2_EX = 5'd6;
    #1;
    checkOutput("fwd_a_only_a", 32'(bus.fwd_a), 32'h1);
    checkOutput("fwd_b_only_a", 32'(bus.fwd_b), 32'h0);
    bus.rd_WB  = 5'd0;
    bus.rs1_EX = 5'd0;
    bus.rs2_EX = 5'd0;
    #1;
    checkOutput("fwd_a_x0", 32'(bus.fwd_a), 32'h0);
    checkOutput("fwd_b_x0", 32'(bus.fwd_b), 32'h0);
    bus.regwrite_WB = 1'b0;

    bus.redirect_EX = 1'b1;
    bus.target_EX   = 12'h020;
    applyStimulus();
    bus.redirect_EX = 1'b0;
    checkOutput("redir_pc",  32'(bus.pc_FETCH), 32'h020);
    checkOutput("redir_vex", 32'(bus.valid_EX), 32'h0);
    checkOutput("redir_ir",  bus.instret,       32'd5);
    applyStimulus();
    checkOutput("redir_pc_next", 32'(bus.pc_FETCH), 32'h021);
    checkOutput("redir_vwb",     32'(bus.valid_WB), 32'h0);
    checkOutput("redir_ir_next", bus.instret,       32'd6);

    // Forwarding must stay off while WB holds the squashed bubble
    bus.regwrite_WB = 1'b1;
    bus.rd_WB       = 5'd5;
    bus.rs1_EX      = 5'd5;
    bus.rs2_EX      = 5'd5;
    #1;
    checkOutput("fwd_a_bubble", 32'(bus.fwd_a), 32'h0);
    checkOutput("fwd_b_bubble", 32'(bus.fwd_b), 32'h0);
    bus.regwrite_WB = 1'b0;

    applyStimulus();
    checkOutput("skip_ir", bus.instret, 32'd6);
    bus.halt_req = 1'b1;
    applyStimulus();
    checkOutput("halt_halted",   32'(bus.halted),   32'h1);
    checkOutput("halt_fetch_en", 32'(bus.fetch_en), 32'h0);
    checkOutput("halt_pc",       32'(bus.pc_FETCH), 32'h023);
    checkOutput("halt_vex",      32'(bus.valid_EX), 32'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("halt_drain_ir", bus.instret,       32'd9);
    applyStimulus();
    checkOutput("halt_hold_ir",  bus.instret,       32'd9);
    checkOutput("halt_hold_pc",  32'(bus.pc_FETCH), 32'h023);

    bus.run_req = 1'b1;
    applyStimulus();
    checkOutput("prio_halt_wins", 32'(bus.halted), 32'h1);

    bus.halt_req = 1'b0;
    bus.run_req  = 1'b0;
    bus.step_req = 1'b1;
    applyStimulus();
    bus.step_req = 1'b0;
    checkOutput("step_if_fetch", 32'(bus.fetch_en), 32'h1);
    checkOutput("step_if_ack",   32'(bus.step_ack), 32'h0);
    applyStimulus();
    checkOutput("step_ex_pc",    32'(bus.pc_FETCH), 32'h024);
    checkOutput("step_ex_fetch", 32'(bus.fetch_en), 32'h0);
    checkOutput("step_ex_ack",   32'(bus.step_ack), 32'h0);
    applyStimulus();
    checkOutput("step_wb_ack",   32'(bus.step_ack), 32'h1);
    checkOutput("step_wb_vwb",   32'(bus.valid_WB), 32'h1);
    applyStimulus();
    checkOutput("step_done_ack", 32'(bus.step_ack), 32'h0);
    checkOutput("step_done_hlt", 32'(bus.halted),   32'h1);
    checkOutput("step_done_ir",  bus.instret,       32'd10);
    checkOutput("step_done_pc",  32'(bus.pc_FETCH), 32'h024);

    bus.halt_req = 1'b1;
    bus.run_req  = 1'b1;
    applyStimulus();
    checkOutput("prio_both", 32'(bus.halted), 32'h1);
    bus.halt_req = 1'b0;
    applyStimulus();
    checkOutput("resume_halted", 32'(bus.halted),   32'h0);
    checkOutput("resume_fetch",  32'(bus.fetch_en), 32'h1);

    // A redirect presented against an EX bubble must not move the PC
    bus.run_req     = 1'b0;
    bus.redirect_EX = 1'b1;
    bus.target_EX   = 12'h100;
    applyStimulus();
    bus.redirect_EX = 1'b0;
    checkOutput("redir_ignored_pc", 32'(bus.pc_FETCH), 32'h025);

    bus.halt_req = 1'b1;
    applyStimulus();
    applyStimulus();
    bus.halt_req = 1'b0;
    bus.step_req = 1'b1;
    applyStimulus();
    bus.step_req = 1'b0;
    applyStimulus();
    checkOutput("pre_rst_step_ex_vex", 32'(bus.valid_EX), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_pc",       32'(bus.pc_FETCH), 32'h0);
    checkOutput("arst_halted",   32'(bus.halted),   32'h0);
    checkOutput("arst_instret",  bus.instret,       32'h0);
    checkOutput("arst_vex",      32'(bus.valid_EX), 32'h0);
    checkOutput("arst_vwb",      32'(bus.valid_WB), 32'h0);
    checkOutput("arst_step_ack", 32'(bus.step_ack), 32'h0);
    #2;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("reboot_fetch_en_%0d", i), 32'(bus.fetch_en), 32'h0);
    end
    applyStimulus();
    checkOutput("reboot_run", 32'(bus.fetch_en), 32'h1);
    applyStimulus();
    bus.redirect_EX = 1'b1;
    bus.target_EX   = 12'hFFF;
    applyStimulus();
    bus.redirect_EX = 1'b0;
    checkOutput("wrap_top", 32'(bus.pc_FETCH), 32'hFFF);
    applyStimulus();
    checkOutput("wrap_zero", 32'(bus.pc_FETCH), 32'h000);
    checkOutput("wrap_vex",  32'(bus.valid_EX), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
